// File: rtl/gpio_ctrl.sv
// gpio_ctrl: req/ack register controller for the GPIO pin block; GPIO_CTRL_BOTH_EDGE_EN enables both-edge pin interrupts.
module gpio_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [2:0]       i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_ack,
  output logic [WIDTH-1:0] o_rdata,
  output logic [WIDTH-1:0] o_DDIR,
  output logic [WIDTH-1:0] o_DOUT,
  output logic             o_WER,
  output logic             o_WEO,
  input  logic [WIDTH-1:0] i_DIN,
  output logic             o_irq
);
  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;
  state_t r_state, w_next;
  logic                                r_we, r_wer, r_weo, r_irq;
  logic [2:0]                          r_addr;
  logic [WIDTH-1:0]                    r_wdata, r_ddir, r_dout, r_en, r_stat, r_rdata, r_prev;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   r_sync;
  logic                                w_wr;
  logic [WIDTH-1:0]                    w_sync, w_edge, w_set, w_clr, w_rd_val;
  always_comb begin
    w_next   = IDLE;
    w_next   = r_state == IDLE ? (i_req ? EXEC : IDLE) : r_state == EXEC ? ACK : IDLE;
    w_wr     = (r_state == EXEC) && r_we;
    w_sync   = r_sync[SYNC_STAGES-1];
`ifdef GPIO_CTRL_BOTH_EDGE_EN
    w_edge   = w_sync ^ r_prev;
`else
    w_edge   = w_sync & ~r_prev;
`endif
    w_set    = w_edge & r_en & r_ddir;
    w_clr    = (w_wr && r_addr == 3'd7) ? r_wdata : '0;
    w_rd_val = r_addr == 3'd0 ? r_ddir :
               r_addr == 3'd5 ? w_sync :
               r_addr == 3'd6 ? r_en   :
               r_addr == 3'd7 ? r_stat : r_dout;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ddir  <= '0;
      r_dout  <= '0;
      r_en    <= '0;
      r_stat  <= '0;
      r_rdata <= '0;
      r_wer   <= 1'b0;
      r_weo   <= 1'b0;
      r_irq   <= 1'b0;
      r_sync  <= '0;
      r_prev  <= '0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_DIN};
      r_prev  <= w_sync;
      r_stat  <= (r_stat & ~w_clr) | w_set;
      r_irq   <= |r_stat;
      r_wer   <= w_wr && r_addr == 3'd0;
      r_weo   <= w_wr && r_addr >= 3'd1 && r_addr <= 3'd4;
      r_rdata <= (r_state == EXEC && !r_we) ? w_rd_val : '0;
      if (r_state == IDLE && i_req) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (w_wr && r_addr == 3'd0) r_ddir <= r_wdata;
      if (w_wr && r_addr == 3'd6) r_en <= r_wdata;
      if (w_wr) r_dout <= r_addr == 3'd1 ? r_wdata :
                          r_addr == 3'd2 ? (r_dout | r_wdata) :
                          r_addr == 3'd3 ? (r_dout & ~r_wdata) :
                          r_addr == 3'd4 ? (r_dout ^ r_wdata) : r_dout;
    end
  end
  assign o_ack   = r_state == ACK;
  assign o_rdata = r_rdata;
  assign o_DDIR  = r_ddir;
  assign o_DOUT  = r_dout;
  assign o_WER   = r_wer;
  assign o_WEO   = r_weo;
  assign o_irq   = r_irq;
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed stimulus with a transaction-level model compared every cycle.
module tb_gpio_ctrl;
  localparam int W = 32;
  localparam int S = 2;
`ifdef GPIO_CTRL_BOTH_EDGE_EN
  localparam logic BOTH = 1'b1;
`else
  localparam logic BOTH = 1'b0;
`endif
  logic         i_clk = 1'b0, i_rst_n = 1'b0, i_req = 1'b0, i_we = 1'b0;
  logic [2:0]   i_addr = '0;
  logic [W-1:0] i_wdata = '0, i_DIN = '0;
  logic         o_ack, o_WER, o_WEO, o_irq;
  logic [W-1:0] o_rdata, o_DDIR, o_DOUT;
  int           checks = 0, errors = 0, n_wer = 0, n_weo = 0;
  bit           chk_en = 1'b0;

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_ack(o_ack), .o_rdata(o_rdata), .o_DDIR(o_DDIR), .o_DOUT(o_DOUT),
    .o_WER(o_WER), .o_WEO(o_WEO), .i_DIN(i_DIN), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: register file, pin sample history (index 0 = newest) and transaction phase.
  logic [W-1:0] m_ddir, m_dout, m_en, m_stat, m_rd, t_wd, ev, set_v, clr_v;
  logic [W-1:0] hist [0:S];
  logic         m_irq, t_we;
  logic [2:0]   t_addr;
  int           m_phase;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_ddir = '0; m_dout = '0; m_en = '0; m_stat = '0; m_rd = '0; m_irq = 1'b0;
      t_we = 1'b0; t_addr = '0; t_wd = '0; m_phase = 0;
      for (int i = 0; i <= S; i++) hist[i] = '0;
    end else begin
      ev    = BOTH ? (hist[S-1] ^ hist[S]) : (hist[S-1] & ~hist[S]);
      set_v = ev & m_en & m_ddir;
      clr_v = '0;
      m_irq = |m_stat;
      if (m_phase == 1) begin
        case (t_addr)
          3'd0:    m_rd = m_ddir;
          3'd5:    m_rd = hist[S-1];
          3'd6:    m_rd = m_en;
          3'd7:    m_rd = m_stat;
          default: m_rd = m_dout;
        endcase
        if (t_we)
          case (t_addr)
            3'd0: m_ddir = t_wd;
            3'd1: m_dout = t_wd;
            3'd2: m_dout = m_dout | t_wd;
            3'd3: m_dout = m_dout & ~t_wd;
            3'd4: m_dout = m_dout ^ t_wd;
            3'd6: m_en = t_wd;
            3'd7: clr_v = t_wd;
            default: ;
          endcase
      end
      m_stat = (m_stat & ~clr_v) | set_v;
      if (m_phase == 0 && i_req) begin
        t_we = i_we; t_addr = i_addr; t_wd = i_wdata; m_phase = 1;
      end else m_phase = m_phase == 1 ? 2 : 0;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = i_DIN;
    end
  end

  always @(negedge i_clk) begin
    logic e_ack;
    if (o_WER) n_wer++;
    if (o_WEO) n_weo++;
    if (chk_en) begin
      e_ack = i_rst_n && m_phase == 2;
      check("ack", o_ack, e_ack);
      check("wer", o_WER, e_ack && t_we && t_addr == 3'd0);
      check("weo", o_WEO, e_ack && t_we && t_addr >= 3'd1 && t_addr <= 3'd4);
      check("rdata", o_rdata, (e_ack && !t_we) ? m_rd : '0);
      check("ddir", o_DDIR, m_ddir);
      check("dout", o_DOUT, m_dout);
      check("irq", o_irq, m_irq);
    end
  end

  task automatic xact(input logic we, input logic [2:0] addr, input logic [W-1:0] wd,
                      output logic [W-1:0] rd);
    int n;
    @(posedge i_clk); #2;
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wd;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_ack && n < 10);
    check("ack_latency", n, 3);
    rd = o_rdata;
    @(posedge i_clk); #2;
    i_req = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rd;
    int w0, v0;
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge i_clk);
    check("rst_ddir", o_DDIR, '0);
    check("rst_irq", o_irq, '0);
    i_DIN = 32'hA5A5_0000;
    repeat (4) @(posedge i_clk);
    xact(1'b0, 3'd5, '0, rd);
    check("din_read", rd, 32'hA5A5_0000);
    w0 = n_wer; v0 = n_weo;
    xact(1'b1, 3'd0, 32'h0000_FFFF, rd);
    check("ddir_val", o_DDIR, 32'h0000_FFFF);
    check("ddir_wer_pulses", n_wer - w0, 1);
    check("ddir_weo_pulses", n_weo - v0, 0);
    v0 = n_weo;
    xact(1'b1, 3'd1, 32'h0000_00F0, rd);
    xact(1'b1, 3'd2, 32'h0000_000F, rd);
    xact(1'b1, 3'd3, 32'h0000_00C0, rd);
    xact(1'b1, 3'd4, 32'h0000_0101, rd);
    check("dout_weo_pulses", n_weo - v0, 4);
    xact(1'b0, 3'd1, '0, rd);
    check("dout_read", rd, 32'h0000_013E);
    xact(1'b0, 3'd3, '0, rd);
    check("clr_reads_dout", rd, 32'h0000_013E);
    xact(1'b1, 3'd6, 32'h1, rd);
    @(posedge i_clk); #2 i_DIN[0] = 1'b1;
    repeat (S + 2) @(posedge i_clk);
    @(negedge i_clk);
    check("irq_rise", o_irq, 1'b1);
    xact(1'b0, 3'd7, '0, rd);
    check("stat_read", rd, 32'h1);
    xact(1'b1, 3'd7, 32'h1, rd);
    @(negedge i_clk);
    check("irq_cleared", o_irq, 1'b0);
    @(posedge i_clk); #2 i_DIN[0] = 1'b0;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    check("irq_fall", o_irq, BOTH);
    xact(1'b1, 3'd7, 32'h1, rd);
    @(posedge i_clk); #2 i_DIN[0] = 1'b1;
    repeat (5) @(posedge i_clk);
    #2 i_DIN[0] = 1'b0;
    repeat (5) @(posedge i_clk);
    #2 i_DIN[0] = 1'b1;
    xact(1'b1, 3'd7, 32'h1, rd);
    xact(1'b0, 3'd7, '0, rd);
    check("set_beats_clear", rd, 32'h1);
    v0 = n_weo;
    @(posedge i_clk); #2;
    i_req = 1'b1; i_we = 1'b1; i_addr = 3'd1; i_wdata = 32'h55;
    @(posedge i_clk); #2 i_rst_n = 1'b0;
    @(negedge i_clk); #2;
    i_rst_n = 1'b1; i_req = 1'b0;
    repeat (4) @(negedge i_clk);
    check("abort_dout", o_DOUT, '0);
    check("abort_ddir", o_DDIR, '0);
    check("abort_weo", n_weo - v0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
